// File: rtl/axi_atomics_aw_w_arbiter.sv
// Write-side arbiter ahead of the atomics adapter: round-robin AW, W locked to AW order
// through a FIFO of grant indices, B routed back by the index prefixed to the ID.
module axi_atomics_aw_w_arbiter #(
  parameter int unsigned NUM_SLV        = 2,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AW_PLD_WIDTH   = 96,
  parameter int unsigned W_FIFO_DEPTH   = 4,
  localparam int unsigned IDX_W  = $clog2(NUM_SLV),
  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NUM_SLV-1:0]                slv_aw_valid_i,
  output logic [NUM_SLV-1:0]                slv_aw_ready_o,
  input  logic [NUM_SLV*AXI_ID_WIDTH-1:0]   slv_aw_id_i,
  input  logic [NUM_SLV*AW_PLD_WIDTH-1:0]   slv_aw_pld_i,
  input  logic [NUM_SLV-1:0]                slv_w_valid_i,
  output logic [NUM_SLV-1:0]                slv_w_ready_o,
  input  logic [NUM_SLV*AXI_DATA_WIDTH-1:0] slv_w_data_i,
  input  logic [NUM_SLV*STRB_W-1:0]         slv_w_strb_i,
  input  logic [NUM_SLV-1:0]                slv_w_last_i,
  output logic [NUM_SLV-1:0]                slv_b_valid_o,
  input  logic [NUM_SLV-1:0]                slv_b_ready_i,
  output logic [NUM_SLV*AXI_ID_WIDTH-1:0]   slv_b_id_o,
  output logic [NUM_SLV*2-1:0]              slv_b_resp_o,
  output logic                              mst_aw_valid_o,
  input  logic                              mst_aw_ready_i,
  output logic [AXI_ID_WIDTH+IDX_W-1:0]     mst_aw_id_o,
  output logic [AW_PLD_WIDTH-1:0]           mst_aw_pld_o,
  output logic                              mst_w_valid_o,
  input  logic                              mst_w_ready_i,
  output logic [AXI_DATA_WIDTH-1:0]         mst_w_data_o,
  output logic [STRB_W-1:0]                 mst_w_strb_o,
  output logic                              mst_w_last_o,
  input  logic                              mst_b_valid_i,
  output logic                              mst_b_ready_o,
  input  logic [AXI_ID_WIDTH+IDX_W-1:0]     mst_b_id_i,
  input  logic [1:0]                        mst_b_resp_i
);

  localparam int unsigned PTR_W = (W_FIFO_DEPTH > 1) ? $clog2(W_FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(W_FIFO_DEPTH + 1);
  localparam int unsigned MID_W = AXI_ID_WIDTH + IDX_W;

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] aw_idx_q, aw_idx_d;
  logic             aw_lock_q, aw_lock_d;
  logic [IDX_W-1:0] fifo_mem_q [W_FIFO_DEPTH];
  logic [IDX_W-1:0] fifo_mem_d [W_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [IDX_W-1:0] gnt_idx, cand, w_head, b_idx;
  logic             gnt_vld, fifo_full, fifo_empty, aw_hs, w_pop, b_in_range;

  assign fifo_full  = (cnt_q == CNT_W'(W_FIFO_DEPTH));
  assign fifo_empty = (cnt_q == '0);

  // Descending scan so the candidate closest to rr_ptr is the one left standing.
  always_comb begin
    gnt_idx = aw_idx_q;
    gnt_vld = 1'b0;
    cand    = '0;
    if (aw_lock_q) begin
      gnt_vld = slv_aw_valid_i[aw_idx_q];
    end else begin
      for (int k = NUM_SLV - 1; k >= 0; k--) begin
        cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_SLV);
        if (slv_aw_valid_i[cand]) begin
          gnt_idx = cand;
          gnt_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    mst_aw_valid_o          = rst_ni & gnt_vld & ~fifo_full;
    aw_hs                   = mst_aw_valid_o & mst_aw_ready_i;
    slv_aw_ready_o          = '0;
    slv_aw_ready_o[gnt_idx] = aw_hs;
    mst_aw_id_o             = {gnt_idx, slv_aw_id_i[gnt_idx*AXI_ID_WIDTH +: AXI_ID_WIDTH]};
    mst_aw_pld_o            = slv_aw_pld_i[gnt_idx*AW_PLD_WIDTH +: AW_PLD_WIDTH];
  end

  always_comb begin
    w_head                = fifo_mem_q[rd_ptr_q];
    mst_w_valid_o         = rst_ni & ~fifo_empty & slv_w_valid_i[w_head];
    mst_w_data_o          = slv_w_data_i[w_head*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
    mst_w_strb_o          = slv_w_strb_i[w_head*STRB_W +: STRB_W];
    mst_w_last_o          = slv_w_last_i[w_head];
    slv_w_ready_o         = '0;
    slv_w_ready_o[w_head] = rst_ni & ~fifo_empty & mst_w_ready_i;
    w_pop                 = mst_w_valid_o & mst_w_ready_i & mst_w_last_o;
  end

  // Out-of-range prefixes are sunk so the adapter can never stall on them.
  always_comb begin
    b_idx         = mst_b_id_i[MID_W-1 -: IDX_W];
    b_in_range    = (32'(b_idx) < NUM_SLV);
    slv_b_valid_o = '0;
    if (b_in_range) slv_b_valid_o[b_idx] = rst_ni & mst_b_valid_i;
    mst_b_ready_o = rst_ni & (b_in_range ? slv_b_ready_i[b_idx] : 1'b1);
    slv_b_id_o    = {NUM_SLV{mst_b_id_i[AXI_ID_WIDTH-1:0]}};
    slv_b_resp_o  = {NUM_SLV{mst_b_resp_i}};
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    aw_lock_d  = aw_lock_q;
    aw_idx_d   = aw_idx_q;
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (aw_hs) begin
      rr_ptr_d             = IDX_W'((int'(gnt_idx) + 1) % NUM_SLV);
      aw_lock_d            = 1'b0;
      fifo_mem_d[wr_ptr_q] = gnt_idx;
      wr_ptr_d = (wr_ptr_q == PTR_W'(W_FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end else if (mst_aw_valid_o) begin
      aw_lock_d = 1'b1;
      aw_idx_d  = gnt_idx;
    end
    if (w_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(W_FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    cnt_d = cnt_q + CNT_W'(aw_hs) - CNT_W'(w_pop);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr_q  <= '0;
      aw_lock_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      aw_lock_q <= aw_lock_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    aw_idx_q   <= aw_idx_d;
    fifo_mem_q <= fifo_mem_d;
  end

  a_no_push_full:  assert property (@(posedge clk_i) disable iff (!rst_ni) !(aw_hs && fifo_full));
  a_no_pop_empty:  assert property (@(posedge clk_i) disable iff (!rst_ni) !(w_pop && fifo_empty));
  a_locked_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                    aw_lock_q |-> slv_aw_valid_i[aw_idx_q]);
  a_b_idx_range:   assert property (@(posedge clk_i) disable iff (!rst_ni)
                                    mst_b_valid_i |-> b_in_range);

endmodule

// File: tb/tb_axi_atomics_aw_w_arbiter.sv
// Bench for axi_atomics_aw_w_arbiter: B routing table, directed AW/W sequences,
// and randomized traffic against a queue-based reference model.
module tb_axi_atomics_aw_w_arbiter;
  localparam int N = 2, IW = 4, DW = 64, PW = 96, D = 4, SW = DW / 8, XW = 1;

  logic clk = 1'b0;
  logic rst_ni;
  logic [N-1:0]    slv_aw_valid, slv_aw_ready, slv_w_valid, slv_w_ready, slv_w_last;
  logic [N-1:0]    slv_b_valid, slv_b_ready;
  logic [N*IW-1:0] slv_aw_id, slv_b_id;
  logic [N*PW-1:0] slv_aw_pld;
  logic [N*DW-1:0] slv_w_data;
  logic [N*SW-1:0] slv_w_strb;
  logic [N*2-1:0]  slv_b_resp;
  logic            mst_aw_valid, mst_aw_ready, mst_w_valid, mst_w_ready, mst_w_last;
  logic            mst_b_valid, mst_b_ready;
  logic [IW+XW-1:0] mst_aw_id, mst_b_id;
  logic [PW-1:0]   mst_aw_pld;
  logic [DW-1:0]   mst_w_data;
  logic [SW-1:0]   mst_w_strb;
  logic [1:0]      mst_b_resp;

  int checks = 0;
  int errors = 0;

  axi_atomics_aw_w_arbiter #(.NUM_SLV(N), .AXI_ID_WIDTH(IW), .AXI_DATA_WIDTH(DW),
                             .AW_PLD_WIDTH(PW), .W_FIFO_DEPTH(D)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .slv_aw_valid_i(slv_aw_valid), .slv_aw_ready_o(slv_aw_ready),
    .slv_aw_id_i(slv_aw_id), .slv_aw_pld_i(slv_aw_pld),
    .slv_w_valid_i(slv_w_valid), .slv_w_ready_o(slv_w_ready),
    .slv_w_data_i(slv_w_data), .slv_w_strb_i(slv_w_strb), .slv_w_last_i(slv_w_last),
    .slv_b_valid_o(slv_b_valid), .slv_b_ready_i(slv_b_ready),
    .slv_b_id_o(slv_b_id), .slv_b_resp_o(slv_b_resp),
    .mst_aw_valid_o(mst_aw_valid), .mst_aw_ready_i(mst_aw_ready),
    .mst_aw_id_o(mst_aw_id), .mst_aw_pld_o(mst_aw_pld),
    .mst_w_valid_o(mst_w_valid), .mst_w_ready_i(mst_w_ready),
    .mst_w_data_o(mst_w_data), .mst_w_strb_o(mst_w_strb), .mst_w_last_o(mst_w_last),
    .mst_b_valid_i(mst_b_valid), .mst_b_ready_o(mst_b_ready),
    .mst_b_id_i(mst_b_id), .mst_b_resp_i(mst_b_resp)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    slv_aw_valid = '0; slv_w_valid = '0; slv_w_last = '0; slv_b_ready = '0;
    mst_aw_ready = 1'b0; mst_w_ready = 1'b0; mst_b_valid = 1'b0;
    mst_b_id = '0; mst_b_resp = '0;
    slv_aw_id  = {4'h5, 4'hA};
    slv_aw_pld = {96'hBBBB_BBBB_BBBB_BBBB_BBBB_BBBB, 96'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA};
    slv_w_data = {64'h1111_2222_3333_4444, 64'h0};
    slv_w_strb = {8'hF0, 8'h0F};
  endtask

  task automatic do_reset();
    idle();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       bv;
    logic [4:0] bid;
    logic [1:0] bresp;
    logic [1:0] sready;
    logic [1:0] e_valid;
    logic       e_ready;
  } bvec_t;

  bvec_t btab [6];

  initial begin
    logic [IW+XW-1:0] e_id;
    logic [N-1:0]     e_mask, acc;
    int               rr, held, g, h, bi;
    int               wq[$];

    btab[0] = '{1'b1, 5'b1_0110, 2'b10, 2'b11, 2'b10, 1'b1};
    btab[1] = '{1'b1, 5'b1_0110, 2'b01, 2'b01, 2'b10, 1'b0};
    btab[2] = '{1'b1, 5'b0_0011, 2'b11, 2'b01, 2'b01, 1'b1};
    btab[3] = '{1'b1, 5'b0_0011, 2'b00, 2'b10, 2'b01, 1'b0};
    btab[4] = '{1'b0, 5'b1_0110, 2'b01, 2'b11, 2'b00, 1'b1};
    btab[5] = '{1'b0, 5'b0_1001, 2'b10, 2'b10, 2'b00, 1'b0};

    // Reset with every input valid/ready high: all handshake outputs must be low.
    idle();
    rst_ni = 1'b0;
    slv_aw_valid = '1; slv_w_valid = '1; slv_w_last = '1; slv_b_ready = '1;
    mst_aw_ready = 1'b1; mst_w_ready = 1'b1; mst_b_valid = 1'b1; mst_b_id = 5'b1_0000;
    repeat (2) begin
      @(posedge clk);
      #2;
      chk("rst_aw_valid", mst_aw_valid, 0);
      chk("rst_aw_ready", slv_aw_ready, 0);
      chk("rst_w_valid", mst_w_valid, 0);
      chk("rst_w_ready", slv_w_ready, 0);
      chk("rst_b_valid", slv_b_valid, 0);
      chk("rst_b_ready", mst_b_ready, 0);
    end
    rst_ni = 1'b1;
    #1;
    chk("rst_first_valid", mst_aw_valid, 1);
    chk("rst_first_gnt", mst_aw_id, {1'b0, 4'hA});

    // B routing table
    do_reset();
    foreach (btab[i]) begin
      mst_b_valid = btab[i].bv; mst_b_id = btab[i].bid;
      mst_b_resp = btab[i].bresp; slv_b_ready = btab[i].sready;
      #1;
      chk("b_valid", slv_b_valid, btab[i].e_valid);
      chk("b_ready", mst_b_ready, btab[i].e_ready);
      if (btab[i].bv) begin
        bi = int'(btab[i].bid[4]);
        chk("b_id", slv_b_id[bi*IW +: IW], btab[i].bid[3:0]);
        chk("b_resp", slv_b_resp[bi*2 +: 2], btab[i].bresp);
      end
      next_cycle();
    end

    // Round-robin with both requesters always valid
    do_reset();
    slv_aw_valid = 2'b11; mst_aw_ready = 1'b1;
    slv_w_valid = 2'b11; slv_w_last = 2'b11; mst_w_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_gnt", mst_aw_id, (k % 2 == 1) ? {1'b1, 4'h5} : {1'b0, 4'hA});
      next_cycle();
    end

    // Backpressure lock: req0 stays granted until its handshake
    do_reset();
    slv_aw_valid = 2'b01; mst_aw_ready = 1'b1;
    #1 chk("lock_pre_gnt", mst_aw_id, {1'b0, 4'hA});
    next_cycle();
    mst_aw_ready = 1'b0;
    #1 chk("lock_first_gnt", mst_aw_id, {1'b0, 4'hA});
    next_cycle();
    slv_aw_valid = 2'b11;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("lock_hold_id", mst_aw_id, {1'b0, 4'hA});
      chk("lock_hold_pld", mst_aw_pld, slv_aw_pld[PW-1:0]);
      chk("lock_hold_rdy", slv_aw_ready, 2'b00);
      next_cycle();
    end
    mst_aw_ready = 1'b1;
    #1;
    chk("lock_hs_rdy", slv_aw_ready, 2'b01);
    chk("lock_hs_id", mst_aw_id, {1'b0, 4'hA});
    next_cycle();
    slv_aw_valid = 2'b10;
    #1;
    chk("lock_next_gnt", mst_aw_id, {1'b1, 4'h5});
    chk("lock_next_rdy", slv_aw_ready, 2'b10);
    next_cycle();

    // W ordering: AW0 (4 beats) then AW1 (1 beat), W1 offered first
    do_reset();
    slv_aw_valid = 2'b01; mst_aw_ready = 1'b1;
    slv_w_valid = 2'b01; mst_w_ready = 1'b1;
    #1;
    chk("w_no_bypass", mst_w_valid, 0);
    chk("w_no_bypass_rdy", slv_w_ready, 2'b00);
    next_cycle();
    slv_aw_valid = 2'b10; slv_w_valid = 2'b10; slv_w_last = 2'b10;
    #1;
    chk("w1_stall", mst_w_valid, 0);
    chk("w1_stall_rdy", slv_w_ready, 2'b01);
    next_cycle();
    slv_aw_valid = 2'b00;
    for (int k = 0; k < 4; k++) begin
      slv_w_valid = 2'b11;
      slv_w_data[DW-1:0] = 64'hD0 + 64'(k);
      slv_w_last[0] = (k == 3);
      #1;
      chk("w0_valid", mst_w_valid, 1);
      chk("w0_data", mst_w_data, 64'hD0 + 64'(k));
      chk("w0_last", mst_w_last, (k == 3));
      chk("w0_rdy", slv_w_ready, 2'b01);
      next_cycle();
    end
    slv_w_valid = 2'b10;
    #1;
    chk("w1_valid", mst_w_valid, 1);
    chk("w1_data", mst_w_data, 64'h1111_2222_3333_4444);
    chk("w1_strb", mst_w_strb, 8'hF0);
    chk("w1_rdy", slv_w_ready, 2'b10);
    next_cycle();
    #1 chk("w_empty", mst_w_valid, 0);
    next_cycle();

    // FIFO full: four AWs with no W, then one W last frees a slot
    do_reset();
    slv_aw_valid = 2'b01; mst_aw_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1 chk("full_fill", mst_aw_valid, 1);
      next_cycle();
    end
    #1;
    chk("full_block", mst_aw_valid, 0);
    chk("full_block_rdy", slv_aw_ready, 2'b00);
    slv_w_valid = 2'b01; slv_w_last = 2'b01; mst_w_ready = 1'b1;
    #1 chk("full_pop_cycle", mst_aw_valid, 0);
    next_cycle();
    slv_w_valid = 2'b00;
    #1;
    chk("full_regrant", mst_aw_valid, 1);
    chk("full_regrant_rdy", slv_aw_ready, 2'b01);
    next_cycle();

    // Randomized traffic against the queue model
    do_reset();
    rr = 0; held = -1; wq.delete(); acc = '0;
    for (int c = 0; c < 400; c++) begin
      slv_aw_valid &= ~acc;
      for (int i = 0; i < N; i++) begin
        if (!slv_aw_valid[i] && $urandom_range(0, 2) == 0) begin
          slv_aw_valid[i] = 1'b1;
          slv_aw_id[i*IW +: IW] = IW'($urandom);
          slv_aw_pld[i*PW +: PW] = {$urandom, $urandom, $urandom};
        end
      end
      slv_w_valid = N'($urandom); slv_w_last = N'($urandom) & N'($urandom);
      slv_w_data = {$urandom, $urandom, $urandom, $urandom};
      mst_aw_ready = 1'($urandom); mst_w_ready = 1'($urandom);
      mst_b_valid = 1'($urandom); mst_b_id = 5'($urandom);
      mst_b_resp = 2'($urandom); slv_b_ready = N'($urandom);
      #1;
      g = -1;
      if (held >= 0) g = held;
      else if (wq.size() < D) begin
        for (int k = N - 1; k >= 0; k--)
          if (slv_aw_valid[(rr + k) % N]) g = (rr + k) % N;
      end
      chk("rnd_aw_valid", mst_aw_valid, (g >= 0));
      e_mask = '0;
      if (g >= 0) begin
        e_id = {XW'(g), slv_aw_id[g*IW +: IW]};
        chk("rnd_aw_id", mst_aw_id, e_id);
        chk("rnd_aw_pld", mst_aw_pld, slv_aw_pld[g*PW +: PW]);
        e_mask[g] = mst_aw_ready;
      end
      chk("rnd_aw_rdy", slv_aw_ready, e_mask);
      h = (wq.size() > 0) ? wq[0] : -1;
      e_mask = '0;
      if (h >= 0) begin
        e_mask[h] = mst_w_ready;
        chk("rnd_w_valid", mst_w_valid, slv_w_valid[h]);
        if (slv_w_valid[h]) begin
          chk("rnd_w_data", mst_w_data, slv_w_data[h*DW +: DW]);
          chk("rnd_w_last", mst_w_last, slv_w_last[h]);
        end
      end else begin
        chk("rnd_w_valid", mst_w_valid, 0);
      end
      chk("rnd_w_rdy", slv_w_ready, e_mask);
      bi = int'(mst_b_id[IW]);
      e_mask = '0;
      e_mask[bi] = mst_b_valid;
      chk("rnd_b_valid", slv_b_valid, e_mask);
      chk("rnd_b_ready", mst_b_ready, slv_b_ready[bi]);
      chk("rnd_b_id", slv_b_id[bi*IW +: IW], mst_b_id[IW-1:0]);
      acc = '0;
      if (h >= 0 && slv_w_valid[h] && mst_w_ready && slv_w_last[h]) void'(wq.pop_front());
      if (g >= 0) begin
        if (mst_aw_ready) begin
          wq.push_back(g);
          rr = (g + 1) % N;
          held = -1;
          acc[g] = 1'b1;
        end else begin
          held = g;
        end
      end
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
